// File: rtl/axis_switch_route_ctrl_pkg.sv
// Shared types and constants for the stream-switch routing controller.
package axis_switch_route_ctrl_pkg;

    localparam int N_REGIONS = 4;

    // Index width that never collapses to zero for a single-entry table.
    function automatic int clog2s(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COMMIT,
        ST_SETTLE,
        ST_DONE
    } route_ctrl_state_t;

    localparam logic [1:0] STATUS_OK       = 2'b00;
    localparam logic [1:0] STATUS_BAD_DEST = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;

endpackage

// File: rtl/axis_switch_route_ctrl_if.sv
// Config request, stream taps and route outputs of the routing controller.
interface axis_switch_route_ctrl_if #(
    parameter int N_ID = axis_switch_route_ctrl_pkg::N_REGIONS
) ();
    import axis_switch_route_ctrl_pkg::*;

    localparam int N_ID_BITS = clog2s(N_ID);

    logic                         cfg_valid;
    logic                         cfg_ready;
    logic [N_ID_BITS-1:0]         cfg_src;
    logic [7:0]                   cfg_dest;
    logic [N_ID-1:0]              mon_tvalid;
    logic [N_ID-1:0]              mon_tready;
    logic [N_ID-1:0]              mon_tlast;
    logic [N_ID-1:0]              hold;
    logic [N_REGIONS-1:0][7:0]    io_ctrl;
    logic                         done;
    logic [1:0]                   status;
    logic                         busy;

    modport master (
        output cfg_valid, cfg_src, cfg_dest, mon_tvalid, mon_tready, mon_tlast,
        input  cfg_ready, hold, io_ctrl, done, status, busy
    );

    modport slave (
        input  cfg_valid, cfg_src, cfg_dest, mon_tvalid, mon_tready, mon_tlast,
        output cfg_ready, hold, io_ctrl, done, status, busy
    );

endinterface

// File: rtl/axis_switch_route_ctrl_pkt_tracker.sv
// Per-port packet-in-progress flag from passive AXI-Stream taps.
module axis_pkt_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic tvalid,
    input  logic tready,
    input  logic tlast,
    output logic in_pkt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            in_pkt <= 1'b0;
        else if (tvalid && tready)
            in_pkt <= ~tlast;
    end

endmodule

// File: rtl/axis_switch_route_ctrl.sv
// Applies route-change requests to io_ctrl only at packet boundaries:
// hold source, drain, commit, settle, release.
module axis_switch_route_ctrl
    import axis_switch_route_ctrl_pkg::*;
#(
    parameter int N_ID          = N_REGIONS,
    parameter int SETTLE_CYCLES = 4,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axis_switch_route_ctrl_if.slave   bus
);

    localparam int N_ID_BITS = clog2s(N_ID);
    localparam int TO_W      = clog2s(DRAIN_TIMEOUT + 1);
    localparam int ST_W      = clog2s(SETTLE_CYCLES + 1);

    route_ctrl_state_t      state;
    logic [N_ID_BITS-1:0]   src_q;
    logic [7:0]             dest_q;
    logic [TO_W-1:0]        to_cnt;
    logic [ST_W-1:0]        st_cnt;
    logic [N_ID-1:0]        in_pkt;
    logic [N_REGIONS-1:0]   req_oh;
    logic [N_REGIONS-1:0]   sel_oh;
    logic                   drained;

    for (genvar g = 0; g < N_ID; g++) begin : g_trk
        axis_pkt_tracker u_trk (
            .clk    (aclk),
            .rst_n  (aresetn),
            .tvalid (bus.mon_tvalid[g]),
            .tready (bus.mon_tready[g]),
            .tlast  (bus.mon_tlast[g]),
            .in_pkt (in_pkt[g])
        );
    end

    // Compare as int so sources above 2**N_ID_BITS never alias onto low regions.
    function automatic logic [N_REGIONS-1:0] src_onehot(input logic [N_ID_BITS-1:0] s);
        logic [N_REGIONS-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REGIONS; i++)
            oh[i] = (int'(s) == i);
        return oh;
    endfunction

    assign req_oh  = src_onehot(bus.cfg_src);
    assign sel_oh  = src_onehot(src_q);
    assign drained = ~|(sel_oh[N_ID-1:0] & (in_pkt | bus.mon_tvalid));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            src_q         <= '0;
            dest_q        <= '0;
            to_cnt        <= '0;
            st_cnt        <= '0;
            bus.cfg_ready <= 1'b1;
            bus.hold      <= '0;
            bus.done      <= 1'b0;
            bus.status    <= STATUS_OK;
            bus.busy      <= 1'b0;
            for (int i = 0; i < N_REGIONS; i++)
                bus.io_ctrl[i] <= 8'(i);
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cfg_valid) begin
                        src_q         <= bus.cfg_src;
                        dest_q        <= bus.cfg_dest;
                        to_cnt        <= '0;
                        bus.cfg_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (int'(bus.cfg_dest[1:0]) >= N_ID) begin
                            state      <= ST_DONE;
                            bus.done   <= 1'b1;
                            bus.status <= STATUS_BAD_DEST;
                        end else begin
                            state    <= ST_DRAIN;
                            bus.hold <= req_oh[N_ID-1:0];
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        // Route byte is registered on entry so it is live during COMMIT.
                        state <= ST_COMMIT;
                        for (int i = 0; i < N_REGIONS; i++)
                            if (sel_oh[i]) bus.io_ctrl[i] <= dest_q;
                    end else if (to_cnt == TO_W'(DRAIN_TIMEOUT)) begin
                        state      <= ST_DONE;
                        bus.done   <= 1'b1;
                        bus.status <= STATUS_TIMEOUT;
                        bus.hold   <= '0;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state  <= ST_SETTLE;
                    st_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (st_cnt == ST_W'(SETTLE_CYCLES - 1)) begin
                        state      <= ST_DONE;
                        bus.done   <= 1'b1;
                        bus.status <= STATUS_OK;
                        bus.hold   <= '0;
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    bus.cfg_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axis_switch_route_ctrl.md
# axis_switch_route_ctrl

Routing controller for the vFPGA stream switch. It owns the per-region `io_ctrl` route bytes that drive the switch's `tdest` selection, and applies route-change requests from the shell's config path only at packet boundaries. For each request it holds the affected source, waits for that source's in-flight packet to drain, commits the new route, waits for the switch to settle, then releases the source. It sits between the shell's config registers and the `io_ctrl` input of the data switch.

## Interface
Parameters:
- `N_ID`, default `N_REGIONS`: number of vFPGA regions (switch ports).
- `SETTLE_CYCLES`, default 4: cycles held after a commit before the source is released.
- `DRAIN_TIMEOUT`, default 4096: maximum drain wait, in cycles, before the request aborts.

Ports:
- `aclk`, in, 1: the block's single clock.
- `aresetn`, in, 1: asynchronous, active-low reset.
- `cfg_valid`, in, 1: route-change request valid.
- `cfg_ready`, out, 1: controller can accept a request.
- `cfg_src`, in, `N_ID_BITS`: source region whose route changes.
- `cfg_dest`, in, 8: new route byte for that source.
- `mon_tvalid`, in, `N_ID`: passive tap of each source stream (`data_ul_out[i]`).
- `mon_tready`, in, `N_ID`: passive tap of each source stream.
- `mon_tlast`, in, `N_ID`: passive tap of each source stream.
- `hold`, out, `N_ID`: per-source request to stop starting new packets.
- `io_ctrl`, out, `[N_REGIONS-1:0][7:0]`: route bytes; bits [1:0] feed the switch `tdest`.
- `done`, out, 1: one-cycle pulse at the end of every accepted request.
- `status`, out, 2: valid with `done`. 00 = ok, 01 = bad dest, 10 = drain timeout.
- `busy`, out, 1: FSM is not in ST_IDLE.

## Operation
- Packet tracking:
  - One `in_pkt[i]` flag per source.
  - Set on a handshake (`mon_tvalid & mon_tready`) with `mon_tlast` = 0.
  - Cleared on a handshake with `mon_tlast` = 1. A single-beat packet leaves it clear.
- ST_IDLE:
  - `cfg_ready` = 1.
  - On accept, register `src` and `dest`.
  - If `dest[1:0]` ≥ `N_ID`, go to ST_DONE with status 01; `hold` and `io_ctrl` are not touched.
  - Otherwise go to ST_DRAIN.
- ST_DRAIN:
  - `hold[src]` = 1 and the timeout counter runs.
  - Leave when `in_pkt[src]` = 0 and `mon_tvalid[src]` = 0 in the same cycle; go to ST_COMMIT.
  - If the counter reaches `DRAIN_TIMEOUT`, go to ST_DONE with status 10; `io_ctrl` is unchanged.
- ST_COMMIT: one cycle. `io_ctrl[src]` ← `dest`, and the settle counter is cleared.
- ST_SETTLE: `hold[src]` stays 1 for `SETTLE_CYCLES` cycles, then go to ST_DONE with status 00.
- ST_DONE: one cycle. `done` = 1, `hold` all 0, then return to ST_IDLE.
- Only one request is in flight at a time. `cfg_valid` is ignored outside ST_IDLE.
- A request whose `dest` equals the current `io_ctrl[src]` still runs the full sequence.

## Timing
- Reset values: `io_ctrl[i]` = i (every region loops to itself), `hold` = 0, `done` = 0, `status` = 00, `busy` = 0, `cfg_ready` = 1, all `in_pkt` = 0, FSM in ST_IDLE.
- Handshake: a request is accepted at the rising edge where `cfg_valid & cfg_ready`. `hold[src]` rises the next cycle.
- Best-case latency, accept to `done`: DRAIN 1 + COMMIT 1 + `SETTLE_CYCLES` + DONE 1 = 7 cycles at defaults.
- `io_ctrl` updates exactly once per successful request, `SETTLE_CYCLES`+1 cycles before `done`.
- A tlast handshake in cycle t makes the drain condition true in cycle t+1 at the earliest.
- Timeout counter is 13 bits at the default `DRAIN_TIMEOUT`; it saturates and never wraps.
- Reset asserted mid-operation returns everything to the reset values, including `io_ctrl`.
- Packet tracking (`in_pkt`) continues in every FSM state.

## Structure
- Shared package: the `route_ctrl_state_t` enum (ST_IDLE, ST_DRAIN, ST_COMMIT, ST_SETTLE, ST_DONE) and the status encodings. `N_ID_BITS` = `clog2s(N_ID)`, from the existing package.
- Sub-module `axis_pkt_tracker`: per-port `in_pkt` flag from the tvalid/tready/tlast taps, instantiated `N_ID` times.

## Test plan
- Idle source, request src=0 dest=1 → `hold[0]` high for 6 cycles, `io_ctrl[0]` = 8'h01, `done` on cycle 7 with status 00.
- Source 1 mid-packet (3 beats remain, tready always 1), request src=1 dest=0 → `io_ctrl[1]` unchanged until the cycle after the tlast beat, then updated; status 00.
- Request with dest=8'h03 at `N_ID`=2 → `done` one cycle after accept, status 01, `hold` never asserted, `io_ctrl` unchanged.
- Source tvalid held high continuously at `DRAIN_TIMEOUT`=16 → `done` with status 10 after the timeout, `io_ctrl` unchanged, `hold` drops.
- `cfg_valid` held for 3 back-to-back requests → each accepted only in ST_IDLE; exactly 3 `done` pulses, in order.
- `aresetn` pulsed low during ST_SETTLE → `io_ctrl[i]` = i, `hold` = 0, `cfg_ready` = 1 immediately (asynchronous reset).
